// File: rtl/reduce_pkg.sv
// Shared types and helpers for the sequential bit-vector reduction engine.
//   op_e     : request opcode (OR/AND/XOR, their inverses, two reserved codes)
//   state_e  : engine control state
//   base_op / invert_of / identity / combine : opcode decode and 1-bit fold helpers
package reduce_pkg;

    typedef enum logic [2:0] {
        OP_OR   = 3'd0,
        OP_AND  = 3'd1,
        OP_XOR  = 3'd2,
        OP_NOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_XNOR = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Fold the full opcode down to one of OR/AND/XOR; reserved codes behave as OR.
    function automatic op_e base_op(op_e op);
        op_e r;
        case (op)
            OP_AND, OP_NAND: r = OP_AND;
            OP_XOR, OP_XNOR: r = OP_XOR;
            default:         r = OP_OR;
        endcase
        return r;
    endfunction

    // Inverted variants produce the complement of the base reduction.
    function automatic logic invert_of(op_e op);
        return (op == OP_NOR) || (op == OP_NAND) || (op == OP_XNOR);
    endfunction

    // Neutral element of the fold: starting value and pad bit for a short last chunk.
    function automatic logic identity(op_e op);
        return (op == OP_AND) || (op == OP_NAND);
    endfunction

    // One 1-bit fold step under the base operation.
    function automatic logic combine(op_e op, logic a, logic b);
        logic r;
        case (op)
            OP_AND, OP_NAND: r = a & b;
            OP_XOR, OP_XNOR: r = a ^ b;
            default:         r = a | b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/chunk_reduce.sv
// Combinational reduction of one CHUNK-bit slice to a single bit.
//   bits     : slice to reduce (already padded with the identity where needed)
//   op       : base operation (OR/AND/XOR)
//   result_c : reduction of the slice
// Built as a linear fold, one stage per bit, matching the legacy reduction chains.
module chunk_reduce
    import reduce_pkg::*;
#(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] bits,
    input  op_e              op,
    output logic             result_c
);

    // Linear chain seeded with the identity so a chunk reduces exactly like the full fold.
    always_comb begin
        logic stage;
        stage = identity(op);
        for (int unsigned i = 0; i < CHUNK; i++) begin
            stage = combine(op, stage, bits[i]);
        end
        result_c = stage;
    end

endmodule

// File: rtl/reduce_seq.sv
// Multi-cycle WIDTH-bit reduction engine: folds CHUNK bits per cycle into a 1-bit accumulator
// and returns OR/AND/XOR (or the inverse) through a valid/ready pair.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : request present          in_ready  : request accepted when in_valid & in_ready
//   in_op      : opcode (reduce_pkg::op_e) in_vec    : vector to reduce, captured on accept
//   out_valid  : result present (DONE)    out_ready : consumer accepts result
//   out_result : reduction result         busy      : engine in RUN or DONE
module reduce_seq
    import reduce_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_e              in_op,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_result,
    output logic             busy
);

    localparam int unsigned NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned PADW   = NCHUNK * CHUNK - WIDTH;
    localparam int unsigned PW     = NCHUNK * CHUNK;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    state_e            state_q;
    state_e            state_d;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  vec_q;
    op_e               base_q;
    logic              inv_q;
    logic              acc_q;
    logic              result_q;

    logic              accept_c;
    logic              last_c;
    logic [PW-1:0]     vec_pad_c;
    logic [CHUNK-1:0]  chunk_bits_c;
    logic              chunk_res_c;
    logic              acc_next_c;

    // Handshake: a finished result being consumed frees the engine in the same cycle.
    assign in_ready   = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept_c   = in_valid & in_ready;
    assign last_c     = (state_q == RUN) & (cnt_q == LAST);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign out_result = result_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = in_valid ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Widen the captured vector to a whole number of chunks; the pad is the identity so it
    // cannot change the result, and no index ever reaches past WIDTH-1 of the real vector.
    generate
        if (PADW == 0) begin : g_nopad
            assign vec_pad_c = vec_q;
        end else begin : g_pad
            assign vec_pad_c = {{PADW{identity(base_q)}}, vec_q};
        end
    endgenerate

    // Select the chunk addressed by the counter.
    always_comb begin
        chunk_bits_c = '0;
        for (int unsigned k = 0; k < NCHUNK; k++) begin
            if (cnt_q == CW'(k)) begin
                chunk_bits_c = vec_pad_c[k*CHUNK +: CHUNK];
            end
        end
    end

    chunk_reduce #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .bits     (chunk_bits_c),
        .op       (base_q),
        .result_c (chunk_res_c)
    );

    assign acc_next_c = combine(base_q, acc_q, chunk_res_c);

    // Datapath: capture on accept, fold one chunk per RUN cycle, latch the result on the last.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            vec_q    <= '0;
            base_q   <= OP_OR;
            inv_q    <= 1'b0;
            acc_q    <= 1'b0;
            result_q <= 1'b0;
        end else if (accept_c) begin
            cnt_q  <= '0;
            vec_q  <= in_vec;
            base_q <= base_op(in_op);
            inv_q  <= invert_of(in_op);
            acc_q  <= identity(base_op(in_op));
        end else if (state_q == RUN) begin
            acc_q <= acc_next_c;
            if (last_c) begin
                result_q <= acc_next_c ^ inv_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_reduce_seq.sv
// Self-checking bench for reduce_seq: two instances (32/4 and 10/4), a cycle-level
// behavioural model, a per-cycle compare process, directed cases and random traffic.
module tb_reduce_seq;
    import reduce_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst;
    logic [1:0] iv;
    logic [1:0] ordy;
    logic [1:0] irdy;
    logic [1:0] ov;
    logic [1:0] ores;
    logic [1:0] bsy;
    op_e        op_a;
    op_e        op_b;
    logic [31:0] vec_a;
    logic [9:0]  vec_b;

    int n_checks = 0;
    int n_errors = 0;

    int nch [2] = '{8, 3};
    int wid [2] = '{32, 10};

    int   m_rem [2] = '{0, 0};
    logic [1:0] m_valid = 2'b00;
    logic [1:0] m_res   = 2'b00;
    logic [1:0] m_pend  = 2'b00;
    bit   chk_en = 1'b0;

    reduce_seq #(.WIDTH(32), .CHUNK(4)) u_dut_a (
        .clk        (clk),
        .rst        (rst[0]),
        .in_valid   (iv[0]),
        .in_ready   (irdy[0]),
        .in_op      (op_a),
        .in_vec     (vec_a),
        .out_valid  (ov[0]),
        .out_ready  (ordy[0]),
        .out_result (ores[0]),
        .busy       (bsy[0])
    );

    reduce_seq #(.WIDTH(10), .CHUNK(4)) u_dut_b (
        .clk        (clk),
        .rst        (rst[1]),
        .in_valid   (iv[1]),
        .in_ready   (irdy[1]),
        .in_op      (op_b),
        .in_vec     (vec_b),
        .out_valid  (ov[1]),
        .out_ready  (ordy[1]),
        .out_result (ores[1]),
        .busy       (bsy[1])
    );

    // Reference reduction straight from the opcode definition over the first w bits.
    function automatic logic ref_fn(logic [2:0] op, logic [31:0] v, int w);
        logic [31:0] m;
        logic [31:0] x;
        logic r;
        m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        x = v & m;
        case (op)
            3'd1, 3'd4: r = (x == m);
            3'd2, 3'd5: r = ($countones(x) % 2) == 1;
            default:    r = (x != 32'd0);
        endcase
        if (op == 3'd3 || op == 3'd4 || op == 3'd5) r = ~r;
        return r;
    endfunction

    task automatic check(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_ready(int d);
        return (m_rem[d] == 0 && !m_valid[d]) || (m_valid[d] && ordy[d]);
    endfunction

    // Behavioural model: a request finishes nch cycles after acceptance and waits for out_ready.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [2:0]  o;
            logic [31:0] v;
            logic        acc;
            o = (d == 0) ? 3'(op_a) : 3'(op_b);
            v = (d == 0) ? vec_a : {22'd0, vec_b};
            if (rst[d]) begin
                m_rem[d]   = 0;
                m_valid[d] = 1'b0;
                m_res[d]   = 1'b0;
            end else begin
                acc = iv[d] && exp_ready(d);
                if (m_valid[d] && ordy[d]) m_valid[d] = 1'b0;
                if (m_rem[d] > 0) begin
                    m_rem[d]--;
                    if (m_rem[d] == 0) begin
                        m_valid[d] = 1'b1;
                        m_res[d]   = m_pend[d];
                    end
                end
                if (acc) begin
                    m_pend[d] = ref_fn(o, v, wid[d]);
                    m_rem[d]  = nch[d];
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("in_ready[%0d]", d), irdy[d], exp_ready(d));
                check($sformatf("out_valid[%0d]", d), ov[d], m_valid[d]);
                check($sformatf("busy[%0d]", d), bsy[d], (m_rem[d] > 0) || m_valid[d]);
                if (m_valid[d]) check($sformatf("out_result[%0d]", d), ores[d], m_res[d]);
            end
        end
    end

    task automatic set_in(int d, logic val, logic [2:0] op, logic [31:0] v);
        if (d == 0) begin
            iv[0] = val;
            op_a  = op_e'(op);
            vec_a = v;
        end else begin
            iv[1] = val;
            op_b  = op_e'(op);
            vec_b = v[9:0];
        end
    endtask

    // One request from idle with out_ready high; checks latency and result against a literal.
    task automatic run_one(int d, logic [2:0] op, logic [31:0] v, logic exp, string name);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        @(negedge clk); #1;
        ordy[d] = 1'b1;
        set_in(d, 1'b1, op, v);
        @(posedge clk); #1;
        set_in(d, 1'b0, 3'($urandom_range(0, 7)), $urandom);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ov[d]) begin
                seen = 1'b1;
                check_int({name, "_latency"}, lat, nch[d]);
                check({name, "_result"}, ores[d], exp);
                check({name, "_model"}, m_res[d], exp);
            end
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got no out_valid expected one within 40 cycles", name);
        end
        @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected one before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst  = 2'b11;
        iv   = 2'b00;
        ordy = 2'b11;
        op_a = OP_OR;
        op_b = OP_OR;
        vec_a = '0;
        vec_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        rst    = 2'b00;
        chk_en = 1'b1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_in_ready[%0d]", d), irdy[d], 1'b1);
            check($sformatf("reset_out_valid[%0d]", d), ov[d], 1'b0);
            check($sformatf("reset_busy[%0d]", d), bsy[d], 1'b0);
            check($sformatf("reset_out_result[%0d]", d), ores[d], 1'b0);
        end

        run_one(0, 3'd0, 32'h0000_0100, 1'b1, "a_or_0x100");
        run_one(0, 3'd1, 32'hFFFF_FFFF, 1'b1, "a_and_ones");
        run_one(0, 3'd1, 32'hFFFF_FFFE, 1'b0, "a_and_fffe");
        run_one(0, 3'd4, 32'hFFFF_FFFE, 1'b1, "a_nand_fffe");
        run_one(0, 3'd7, 32'h0000_0001, 1'b1, "a_rsv7_one");
        run_one(1, 3'd2, 32'h0000_03FF, 1'b0, "b_xor_3ff");
        run_one(1, 3'd5, 32'h0000_0001, 1'b0, "b_xnor_001");
        run_one(1, 3'd1, 32'h0000_03FF, 1'b1, "b_and_3ff_pad");

        // Backpressure in DONE, then a back-to-back accept as soon as out_ready rises.
        @(negedge clk); #1;
        ordy[0] = 1'b0;
        set_in(0, 1'b1, 3'd2, 32'h0000_0007);
        @(posedge clk); #1;
        set_in(0, 1'b0, 3'd0, 32'hFFFF_FFFF);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (ov[0]) seen = 1'b1;
        end
        check("bp_reached_done", seen, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid_held", ov[0], 1'b1);
            check("bp_out_result_held", ores[0], 1'b1);
            check("bp_in_ready_low", irdy[0], 1'b0);
            @(negedge clk);
        end
        #1;
        set_in(0, 1'b1, 3'd0, 32'h0000_0000);
        ordy[0] = 1'b1;
        #1;
        check("bp_same_cycle_ready", irdy[0], 1'b1);
        @(posedge clk); #1;
        set_in(0, 1'b0, 3'd1, 32'h0);
        @(negedge clk);
        check("b2b_out_valid_dropped", ov[0], 1'b0);
        check("b2b_busy", bsy[0], 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (ov[0]) begin
                seen = 1'b1;
                check("b2b_or_zero_result", ores[0], 1'b0);
            end
        end
        check("b2b_reached_done", seen, 1'b1);
        @(posedge clk);

        // Reset in the middle of RUN discards the request.
        @(negedge clk); #1;
        set_in(0, 1'b1, 3'd0, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        set_in(0, 1'b0, 3'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        check("rst_mid_out_valid", ov[0], 1'b0);
        check("rst_mid_busy", bsy[0], 1'b0);
        check("rst_mid_in_ready", irdy[0], 1'b1);
        run_one(0, 3'd0, 32'h0000_0000, 1'b0, "a_or_zero_after_rst");

        // Random traffic with backpressure and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                set_in(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
                ordy[d] = ($urandom_range(0, 3) != 0);
                rst[d]  = ($urandom_range(0, 299) == 0);
            end
        end
        @(negedge clk); #1;
        rst  = 2'b00;
        iv   = 2'b00;
        ordy = 2'b11;
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
